// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage memory controller: length codes, FSM states, IO base.
package mem_ctrl_pkg;

    localparam logic [1:0] MemLenByte = 2'b00;
    localparam logic [1:0] MemLenHalf = 2'b01;
    localparam logic [1:0] MemLenWord = 2'b10;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    // Length code 2'b11 is treated as a word access.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            MemLenByte: return 3'd1;
            MemLenHalf: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// Combinational sign/zero extender for assembled load data.
module mem_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] value,
    input  logic [1:0]  len,
    input  logic        sign_en,
    output logic [31:0] result
);

    always_comb begin
        result = value;
        case (len)
            MemLenByte: result = {{24{sign_en & value[7]}}, value[7:0]};
            MemLenHalf: result = {{16{sign_en & value[15]}}, value[15:0]};
            default:    result = value;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Serializes MEM-stage load/store requests onto an 8-bit synchronous RAM port.
// Optional MEM_CTRL_IO_STALL_EN: stores into IO space hold while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(IO_BASE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_signed,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_len,
    input  logic [31:0]           mem_w_data,
    output logic [31:0]           mem_r_data,
    output logic                  mem_done,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr
`ifdef MEM_CTRL_IO_STALL_EN
    ,
    input  logic                  io_buffer_full
`endif
);

    state_e                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q, ram_a_q, cur_addr;
    logic [1:0]            len_q;
    logic                  sign_q, is_write_q;
    logic [31:0]           wdata_q, asm_q, ext_val;
    logic [2:0]            cnt, n_bytes;
    logic [1:0]            byte_idx;
    logic                  io_full, stall;

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_full = io_buffer_full;
`else
    assign io_full = 1'b0;
`endif

    assign n_bytes  = len_bytes(len_q);
    assign cur_addr = addr_q + ADDR_WIDTH'(cnt);
    assign byte_idx = cnt[1:0] - 2'd1;
    assign stall    = (state == WRITE) && io_full && (cur_addr >= IO_BASE);

    mem_ext u_ext (
        .value  (asm_q),
        .len    (len_q),
        .sign_en(sign_q),
        .result (ext_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ram_wr     = 1'b0;
        ram_dout   = 8'h00;
        ram_a      = ram_a_q;
        mem_done   = 1'b0;
        mem_r_data = 32'h0;
        case (state)
            IDLE: begin
                if (mem_write)     state_nx = WRITE;
                else if (mem_read) state_nx = READ;
            end
            WRITE: begin
                ram_a    = cur_addr;
                ram_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
                if (!stall) begin
                    ram_wr = 1'b1;
                    if (cnt == n_bytes - 3'd1) state_nx = DONE;
                end
            end
            READ: begin
                // Final cycle only collects the last byte; the address is left as-is.
                if (cnt < n_bytes) ram_a = cur_addr;
                if (cnt == n_bytes) state_nx = DONE;
            end
            DONE: begin
                mem_done   = 1'b1;
                mem_r_data = is_write_q ? 32'h0 : ext_val;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 3'd0;
            addr_q     <= '0;
            ram_a_q    <= '0;
            len_q      <= 2'b00;
            sign_q     <= 1'b0;
            is_write_q <= 1'b0;
            wdata_q    <= 32'h0;
            asm_q      <= 32'h0;
        end else begin
            ram_a_q <= ram_a;
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (mem_write || mem_read) begin
                        addr_q     <= mem_addr;
                        len_q      <= mem_len;
                        sign_q     <= mem_signed;
                        is_write_q <= mem_write;
                        wdata_q    <= mem_w_data;
                        asm_q      <= 32'h0;
                    end
                end
                WRITE: if (!stall) cnt <= cnt + 3'd1;
                READ: begin
                    // ram_din belongs to the address driven one cycle earlier.
                    if (cnt != 3'd0) asm_q[{byte_idx, 3'b000} +: 8] <= ram_din;
                    cnt <= cnt + 3'd1;
                end
                default: cnt <= 3'd0;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder end of the MEM-stage memory request interface.
- Accepts one load/store request at a time: address, length code, signed flag and write data.
- Serializes the request into byte accesses on the 8-bit RAM port and assembles/sign-extends read data.
- Pulses mem_done so the MEM stage releases its stall.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr and ram_a.
- IO_BASE, 32'h0003_0000, first address of memory-mapped IO space; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_read  input  1  load request; held by the requester until mem_done.
- mem_write  input  1  store request; held by the requester until mem_done.
- mem_signed  input  1  1 = sign-extend load result; 0 = zero-extend.
- mem_addr  input  ADDR_WIDTH  byte address of the first byte.
- mem_len  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- mem_w_data  input  32  store data; byte 0 = bits [7:0] (little-endian).
- mem_r_data  output  32  load result; valid only in the mem_done cycle.
- mem_done  output  1  one-cycle completion pulse.
- ram_din  input  8  RAM read data for the address presented in the previous cycle.
- ram_dout  output  8  RAM write byte.
- ram_a  output  ADDR_WIDTH  RAM byte address.
- ram_wr  output  1  1 = write ram_dout to ram_a this cycle.
- io_buffer_full  input  1  present only with MEM_CTRL_IO_STALL_EN.

Behaviour:
- Reset values:
  - mem_done=0, mem_r_data=0, ram_a=0, ram_dout=0, ram_wr=0.
  - State IDLE; byte counter 0.
  - Reset mid-operation aborts immediately; partial stores may remain in RAM.
- Byte count N: 1, 2 or 4, from mem_len.
- IDLE:
  - Samples the request each edge.
  - mem_write has priority if both are high.
  - Latches addr, N, signed and w_data.
  - Goes to WRITE or READ; otherwise stays in IDLE with ram_wr=0.
- WRITE (cycles k = 0..N-1):
  - ram_wr=1, ram_a=addr+k, ram_dout=w_data[8k+7:8k].
  - After byte N-1, go to DONE.
- READ (cycles k = 0..N):
  - For k<N: ram_a=addr+k.
  - For k>=1: ram_din is captured into byte k-1 of the assembly register.
  - After cycle N, go to DONE.
  - ram_wr is 0 throughout.
- DONE (one cycle):
  - mem_done=1.
  - For loads, mem_r_data = assembled value extended from bit 8N-1 per mem_signed.
  - For stores, mem_r_data = 0.
  - Then go to IDLE.
- Latency, counted from the accept edge to the done cycle:
  - Store: N+1 cycles.
  - Load: N+2 cycles.
  - Word load: done 6 cycles after accept.
- Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH.
- Requests arriving outside IDLE are ignored until IDLE.
- A request still high in the IDLE cycle after DONE is executed again. The requester drops or replaces the request on the edge where it sees mem_done.
- ram_a keeps its last value when idle.

Optional Feature:
- Macro: MEM_CTRL_IO_STALL_EN.
- Defined:
  - io_buffer_full port exists.
  - A WRITE cycle whose address >= IO_BASE holds while io_buffer_full=1: ram_wr=0, counter frozen, data unchanged.
  - The byte is written in the first cycle io_buffer_full=0.
  - Completion is delayed accordingly.
- Undefined: port absent; writes never hold.

Decomposition:
- Shared package/config header:
  - mem_len encodings MemLenByte/Half/Word.
  - State encodings (IDLE, READ, WRITE, DONE).
  - IO_BASE default.
- One natural sub-module: mem_ext, a combinational sign/zero extender taking a 32-bit assembled value, mem_len and mem_signed.

Test Plan:
- Store word: 0xDEADBEEF to 0x100 -> ram_wr high 4 cycles, addresses 0x100..0x103, bytes EF,BE,AD,DE; mem_done in 5th cycle after accept.
- Load byte signed: RAM[0x200]=0x80 -> mem_r_data=0xFFFFFF80; unsigned -> 0x00000080; done 3 cycles after accept.
- Load half signed: RAM[0x300..0x301]=34,F2 -> 0xFFFFF234; load word of the same region assembles little-endian.
- Wrap-around: word store at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset: assert rst_n=0 during the 2nd READ byte -> all outputs 0 asynchronously, IDLE after release, a new request completes normally.
- IO stall (macro on): byte store to 0x30000 with io_buffer_full=1 for 3 cycles -> ram_wr held 0 for those cycles, then one write; mem_done 1 cycle later.
